// File: rtl/hour_set_ctrl.sv
// hour_set_ctrl: edits the hour in display form (local or world-clock time)
// and commits it back as a Korean 0..23 BCD hour with a one-cycle load pulse.
// Ports:
//   clk, rst (sync, active-high)
//   set_mode (edit level), btn_up/btn_down/btn_ampm (1-cycle pulses)
//   h24, world_clock (display mode), usa/england/spain (region, usa first)
//   cur_h_ten/cur_h_one (current Korean hour, BCD)
//   edit_h_ten/edit_h_one, edit_am/edit_pm (edited hour as displayed)
//   k_h_ten/k_h_one (committed Korean hour), load, busy
// Optional: define HOUR_SET_TIMEOUT_EN to abandon an edit after
// TIMEOUT_CYCLES consecutive button-free EDIT cycles.
module hour_set_ctrl #(
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       set_mode,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_ampm,
  input  logic       h24,
  input  logic       world_clock,
  input  logic       usa,
  input  logic       england,
  input  logic       spain,
  input  logic [3:0] cur_h_ten,
  input  logic [3:0] cur_h_one,
  output logic [3:0] edit_h_ten,
  output logic [3:0] edit_h_one,
  output logic       edit_am,
  output logic       edit_pm,
  output logic [3:0] k_h_ten,
  output logic [3:0] k_h_one,
  output logic       load,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE, CAPTURE, EDIT, COMMIT
  } state_t;

  state_t     state, state_nx;
  logic       set_q;
  logic [4:0] w, off, k;
  logic [4:0] off_sel, cur, w_cap, w_step, k_sum, disp;
  logic [7:0] cur_raw;
  logic [5:0] diff, ksum6;
  logic       rise, expire, twelve;

  function automatic logic [7:0] to_bcd(input logic [4:0] v);
    logic [3:0] t, o;
    if (v >= 5'd20) begin
      t = 4'd2;
      o = 4'(v - 5'd20);
    end else if (v >= 5'd10) begin
      t = 4'd1;
      o = 4'(v - 5'd10);
    end else begin
      t = 4'd0;
      o = v[3:0];
    end
    return {t, o};
  endfunction

  assign rise = set_mode & ~set_q;

  // Region offset from Korean time; usa wins over england over spain.
  always_comb begin
    off_sel = 5'd0;
    if (world_clock && usa)          off_sel = 5'd14;
    else if (world_clock && england) off_sel = 5'd9;
    else if (world_clock && spain)   off_sel = 5'd8;
  end

  // Out-of-range current hours are treated as midnight.
  assign cur_raw = {4'd0, cur_h_ten} * 8'd10 + {4'd0, cur_h_one};
  assign cur     = (cur_raw >= 8'd24) ? 5'd0 : cur_raw[4:0];
  assign diff    = {1'b0, cur} + 6'd24 - {1'b0, off_sel};
  assign w_cap   = (diff >= 6'd24) ? 5'(diff - 6'd24) : diff[4:0];
  assign ksum6   = {1'b0, w} + {1'b0, off};
  assign k_sum   = (ksum6 >= 6'd24) ? 5'(ksum6 - 6'd24) : ksum6[4:0];
  assign twelve  = ~h24 & ~world_clock;

  // up and down together cancel; ampm only acts when alone and in 12h form.
  always_comb begin
    w_step = w;
    if (btn_up && !btn_down)
      w_step = (w == 5'd23) ? 5'd0 : w + 5'd1;
    else if (btn_down && !btn_up)
      w_step = (w == 5'd0) ? 5'd23 : w - 5'd1;
    else if (btn_ampm && !btn_up && !btn_down && twelve)
      w_step = (w >= 5'd12) ? w - 5'd12 : w + 5'd12;
  end

`ifdef HOUR_SET_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] idle_cnt;
  logic          btn_any;

  assign btn_any = btn_up | btn_down | btn_ampm;

  // Zero outside EDIT, so it is already clear on EDIT entry.
  always_ff @(posedge clk) begin
    if (rst || state != EDIT || btn_any) idle_cnt <= '0;
    else                                 idle_cnt <= idle_cnt + 1'b1;
  end

  assign expire = (state == EDIT) && !btn_any &&
                  (idle_cnt == CW'(TIMEOUT_CYCLES - 1));
`else
  // Parameter only matters when the timeout is built in.
  assign expire = 1'b0 && (TIMEOUT_CYCLES > 0);
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (rise) state_nx = CAPTURE;
      CAPTURE: state_nx = EDIT;
      EDIT: begin
        if (!set_mode)   state_nx = COMMIT;
        else if (expire) state_nx = IDLE;
      end
      COMMIT:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      set_q <= 1'b0;
      w     <= 5'd0;
      off   <= 5'd0;
      k     <= 5'd0;
    end else begin
      set_q <= set_mode;
      if (state == CAPTURE) begin
        off <= off_sel;
        w   <= w_cap;
      end
      if (state == EDIT)   w <= w_step;
      if (state == COMMIT) k <= k_sum;
    end
  end

  always_comb begin
    disp = w;
    if (twelve) begin
      if (w == 5'd0)      disp = 5'd12;
      else if (w > 5'd12) disp = w - 5'd12;
    end
  end

  always_comb begin
    busy = (state != IDLE);
    load = (state == COMMIT);
    {k_h_ten, k_h_one} = (state == COMMIT) ? to_bcd(k_sum) : to_bcd(k);
    {edit_h_ten, edit_h_one} = 8'd0;
    edit_am = 1'b0;
    edit_pm = 1'b0;
    if (state != IDLE) begin
      {edit_h_ten, edit_h_one} = to_bcd(disp);
      edit_am = twelve & (w < 5'd12);
      edit_pm = twelve & (w >= 5'd12);
    end
  end

endmodule

// File: tb/tb_hour_set_ctrl.sv
// tb_hour_set_ctrl: directed scenarios plus randomized traffic against
// a modulo-arithmetic reference model of the hour editor.
module tb_hour_set_ctrl;

  localparam int TO = 8;

  logic       clk = 1'b0;
  logic       rst, set_mode, btn_up, btn_down, btn_ampm;
  logic       h24, world_clock, usa, england, spain;
  logic [3:0] cur_h_ten, cur_h_one;
  logic [3:0] edit_h_ten, edit_h_one, k_h_ten, k_h_one;
  logic       edit_am, edit_pm, load, busy;

  int errors = 0;
  int checks = 0;

  // Model: phase 0 idle, 1 capture, 2 edit, 3 commit.
  int m_ph = 0, m_w = 0, m_off = 0, m_k = 0, m_sq = 0, m_cnt = 0;

  always #5 clk = ~clk;

  hour_set_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .set_mode(set_mode),
    .btn_up(btn_up), .btn_down(btn_down), .btn_ampm(btn_ampm),
    .h24(h24), .world_clock(world_clock),
    .usa(usa), .england(england), .spain(spain),
    .cur_h_ten(cur_h_ten), .cur_h_one(cur_h_one),
    .edit_h_ten(edit_h_ten), .edit_h_one(edit_h_one),
    .edit_am(edit_am), .edit_pm(edit_pm),
    .k_h_ten(k_h_ten), .k_h_one(k_h_one),
    .load(load), .busy(busy)
  );

  task automatic model_step();
    int cur, nph;
    if (rst) begin
      m_ph = 0; m_w = 0; m_off = 0; m_k = 0; m_sq = 0; m_cnt = 0;
      return;
    end
    nph = m_ph;
    case (m_ph)
      0: if (set_mode && m_sq == 0) nph = 1;
      1: begin
        m_off = !world_clock ? 0 : usa ? 14 : england ? 9 : spain ? 8 : 0;
        cur = 10 * cur_h_ten + cur_h_one;
        if (cur >= 24) cur = 0;
        m_w = (cur - m_off + 24) % 24;
        m_cnt = 0;
        nph = 2;
      end
      2: begin
        if (btn_up && !btn_down) m_w = (m_w + 1) % 24;
        else if (btn_down && !btn_up) m_w = (m_w + 23) % 24;
        else if (btn_ampm && !btn_up && !btn_down && !h24 && !world_clock)
          m_w = (m_w + 12) % 24;
        if (btn_up || btn_down || btn_ampm) m_cnt = 0;
        else m_cnt++;
        if (!set_mode) begin
          nph = 3;
          m_k = (m_w + m_off) % 24;
        end
`ifdef HOUR_SET_TIMEOUT_EN
        else if (m_cnt >= TO) nph = 0;
`endif
      end
      default: nph = 0;
    endcase
    m_sq = set_mode;
    m_ph = nph;
  endtask

  function automatic logic [19:0] model_out();
    int shown;
    logic am, pm;
    shown = 0; am = 0; pm = 0;
    if (m_ph != 0) begin
      if (h24 || world_clock) shown = m_w;
      else begin
        shown = (m_w % 12 == 0) ? 12 : m_w % 12;
        am = (m_w < 12);
        pm = (m_w >= 12);
      end
    end
    return {m_ph != 0, m_ph == 3, 4'(m_k / 10), 4'(m_k % 10),
            4'(shown / 10), 4'(shown % 10), am, pm};
  endfunction

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic press(input logic u, input logic d, input logic a);
    btn_up = u; btn_down = d; btn_ampm = a;
    cycle();
    btn_up = 0; btn_down = 0; btn_ampm = 0;
  endtask

  task automatic start_edit(input logic [3:0] t, input logic [3:0] o);
    cur_h_ten = t; cur_h_one = o;
    set_mode = 1;
    cycle();
    cycle();
  endtask

  task automatic test_reset();
    rst = 1;
    cycle();
    cycle();
    checks++;
    if ({busy, load, k_h_ten, k_h_one, edit_h_ten, edit_h_one, edit_am, edit_pm} !== 20'd0) begin
      errors++;
      $display("FAIL reset: got busy=%b load=%b k=%h%h edit=%h%h", busy, load,
               k_h_ten, k_h_one, edit_h_ten, edit_h_one);
    end
    rst = 0;
    cycle();
  endtask

  task automatic test_12h();
    h24 = 0; world_clock = 0;
    start_edit(4'd0, 4'd9);
    checks++;
    if ({busy, edit_h_ten, edit_h_one, edit_am, edit_pm} !== {1'b1, 4'd0, 4'd9, 2'b10}) begin
      errors++;
      $display("FAIL 12h_start: got %h%h am=%b pm=%b want 09 am", edit_h_ten, edit_h_one, edit_am, edit_pm);
    end
    repeat (3) press(1, 0, 0);
    checks++;
    if ({edit_h_ten, edit_h_one, edit_am, edit_pm} !== {4'd1, 4'd2, 2'b01}) begin
      errors++;
      $display("FAIL 12h_up3: got %h%h am=%b pm=%b want 12 pm", edit_h_ten, edit_h_one, edit_am, edit_pm);
    end
    set_mode = 0;
    cycle();
    checks++;
    if ({load, k_h_ten, k_h_one} !== {1'b1, 4'd1, 4'd2}) begin
      errors++;
      $display("FAIL 12h_commit: got load=%b k=%h%h want 1 12", load, k_h_ten, k_h_one);
    end
    cycle();
    checks++;
    if ({busy, load, k_h_ten, k_h_one} !== {2'b00, 4'd1, 4'd2}) begin
      errors++;
      $display("FAIL 12h_hold: got busy=%b load=%b k=%h%h want 0 0 12", busy, load, k_h_ten, k_h_one);
    end
  endtask

  task automatic test_world();
    h24 = 0; world_clock = 1; usa = 1; england = 1;
    start_edit(4'd0, 4'd5);
    checks++;
    if ({edit_h_ten, edit_h_one, edit_am, edit_pm} !== {4'd1, 4'd5, 2'b00}) begin
      errors++;
      $display("FAIL world_start: got %h%h am=%b pm=%b want 15", edit_h_ten, edit_h_one, edit_am, edit_pm);
    end
    repeat (16) press(0, 1, 0);
    checks++;
    if ({edit_h_ten, edit_h_one} !== {4'd2, 4'd3}) begin
      errors++;
      $display("FAIL world_down16: got %h%h want 23", edit_h_ten, edit_h_one);
    end
    usa = 0;
    set_mode = 0;
    cycle();
    checks++;
    if ({load, k_h_ten, k_h_one} !== {1'b1, 4'd1, 4'd3}) begin
      errors++;
      $display("FAIL world_commit: got load=%b k=%h%h want 1 13", load, k_h_ten, k_h_one);
    end
    cycle();
    world_clock = 0; england = 0;
  endtask

  task automatic test_ampm();
    h24 = 0; world_clock = 0;
    start_edit(4'd0, 4'd0);
    checks++;
    if ({edit_h_ten, edit_h_one, edit_am, edit_pm} !== {4'd1, 4'd2, 2'b10}) begin
      errors++;
      $display("FAIL ampm_start: got %h%h am=%b pm=%b want 12 am", edit_h_ten, edit_h_one, edit_am, edit_pm);
    end
    press(0, 0, 1);
    checks++;
    if ({edit_h_ten, edit_h_one, edit_am, edit_pm} !== {4'd1, 4'd2, 2'b01}) begin
      errors++;
      $display("FAIL ampm_toggle: got %h%h am=%b pm=%b want 12 pm", edit_h_ten, edit_h_one, edit_am, edit_pm);
    end
    press(1, 1, 0);
    checks++;
    if ({edit_h_ten, edit_h_one, edit_am, edit_pm} !== {4'd1, 4'd2, 2'b01}) begin
      errors++;
      $display("FAIL ampm_updown: got %h%h am=%b pm=%b want 12 pm", edit_h_ten, edit_h_one, edit_am, edit_pm);
    end
    set_mode = 0;
    cycle();
    checks++;
    if ({load, k_h_ten, k_h_one} !== {1'b1, 4'd1, 4'd2}) begin
      errors++;
      $display("FAIL ampm_commit: got load=%b k=%h%h want 1 12", load, k_h_ten, k_h_one);
    end
    cycle();
  endtask

  task automatic test_h24_wrap();
    h24 = 1;
    start_edit(4'd2, 4'd3);
    press(1, 0, 0);
    checks++;
    if ({edit_h_ten, edit_h_one, edit_am, edit_pm} !== {4'd0, 4'd0, 2'b00}) begin
      errors++;
      $display("FAIL h24_wrap: got %h%h am=%b pm=%b want 00", edit_h_ten, edit_h_one, edit_am, edit_pm);
    end
    set_mode = 0;
    cycle();
    checks++;
    if ({load, k_h_ten, k_h_one} !== {1'b1, 4'd0, 4'd0}) begin
      errors++;
      $display("FAIL h24_commit: got load=%b k=%h%h want 1 00", load, k_h_ten, k_h_one);
    end
    set_mode = 1;
    cycle();
    cycle();
    cycle();
    checks++;
    if ({busy, load} !== 2'b00) begin
      errors++;
      $display("FAIL commit_rise: got busy=%b load=%b want 0 0", busy, load);
    end
    set_mode = 0;
    cycle();
  endtask

  task automatic test_reset_mid_edit();
    h24 = 0;
    start_edit(4'd0, 4'd7);
    press(1, 0, 0);
    press(1, 0, 0);
    rst = 1;
    cycle();
    rst = 0;
    set_mode = 0;
    checks++;
    if ({busy, load, k_h_ten, k_h_one, edit_h_ten, edit_h_one} !== 18'd0) begin
      errors++;
      $display("FAIL rst_mid: got busy=%b load=%b k=%h%h edit=%h%h", busy, load,
               k_h_ten, k_h_one, edit_h_ten, edit_h_one);
    end
    for (int i = 0; i < 4; i++) begin
      cycle();
      checks++;
      if (load !== 1'b0) begin
        errors++;
        $display("FAIL rst_noload: got load=%b want 0 at cycle %0d", load, i);
      end
    end
  endtask

  task automatic test_timeout();
    int n;
    h24 = 0;
    start_edit(4'd0, 4'd3);
`ifdef HOUR_SET_TIMEOUT_EN
    n = TO - 1;
`else
    n = 99;
`endif
    repeat (n) cycle();
    checks++;
    if ({busy, load} !== 2'b10) begin
      errors++;
      $display("FAIL timeout_edit: got busy=%b load=%b want 1 0 after %0d cycles", busy, load, n);
    end
    cycle();
    checks++;
`ifdef HOUR_SET_TIMEOUT_EN
    if ({busy, load, k_h_ten, k_h_one} !== {2'b00, 4'd0, 4'd0}) begin
      errors++;
      $display("FAIL timeout_idle: got busy=%b load=%b k=%h%h want 0 0 00", busy, load, k_h_ten, k_h_one);
    end
`else
    if ({busy, load} !== 2'b10) begin
      errors++;
      $display("FAIL no_timeout: got busy=%b load=%b want 1 0 at cycle 100", busy, load);
    end
`endif
    set_mode = 0;
    cycle();
    cycle();
  endtask

  task automatic test_random();
    logic [19:0] got, exp;
    for (int i = 0; i < 1500; i++) begin
      rst = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 9) == 0) set_mode = ~set_mode;
      btn_up = ($urandom_range(0, 2) == 0);
      btn_down = ($urandom_range(0, 3) == 0);
      btn_ampm = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 15) == 0) begin
        h24 = 1'($urandom);
        world_clock = 1'($urandom);
        usa = 1'($urandom);
        england = 1'($urandom);
        spain = 1'($urandom);
      end
      cur_h_ten = 4'($urandom_range(0, 2));
      cur_h_one = 4'($urandom_range(0, 9));
      cycle();
      got = {busy, load, k_h_ten, k_h_one, edit_h_ten, edit_h_one, edit_am, edit_pm};
      exp = model_out();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL random[%0d]: got %h want %h", i, got, exp);
      end
    end
    btn_up = 0; btn_down = 0; btn_ampm = 0; rst = 0;
  endtask

  initial begin
    rst = 1; set_mode = 0; btn_up = 0; btn_down = 0; btn_ampm = 0;
    h24 = 0; world_clock = 0; usa = 0; england = 0; spain = 0;
    cur_h_ten = 0; cur_h_one = 0;
    test_reset();
    test_12h();
    test_world();
    test_ampm();
    test_h24_wrap();
    test_reset_mid_edit();
    test_timeout();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
